rom_download_writer: RTL and testbench

- Sits between the HPS ioctl download stream and the SDRAM controller's request port; supplies the controller's write traffic during ROM loading.
- Packs incoming ROM bytes into 32-bit little-endian words.
- Buffers packed words in a small FIFO and issues them as SDRAM write requests using the req/ack handshake.
- Throttles the HPS with ioctl_wait and reports busy, done and sticky error flags.

---
 rtl/rom_download_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_rom_download_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_writer.sv
// Packs an HPS ioctl byte stream into 32-bit little-endian words, buffers them
// in a small FIFO and issues them as SDRAM write requests over a req/ack port.
`default_nettype none

module rom_download_writer #(
    parameter int IOCTL_AW   = 20,
    parameter int SDRAM_AW   = 23,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    input  logic                ioctl_download,
    output logic                ioctl_wait,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic [31:0]         sdram_data,
    output logic                sdram_we,
    output logic                sdram_req,
    input  logic                sdram_ack,
    output logic                busy,
    output logic                done,
    output logic                seq_error,
    output logic                overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic                dl_q;
    logic                first_q;
    logic                end_pend_q;
    logic                session_q;
    logic                active_q;
    logic                asm_valid_q;
    logic [31:0]         asm_data_q;
    logic [SDRAM_AW-1:0] asm_addr_q;
    logic [IOCTL_AW-1:0] prev_addr_q;
    logic                seq_err_q;
    logic                ovf_q;
    logic                done_q;

    logic [SDRAM_AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0]         fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [SDRAM_AW-1:0] addr_q;
    logic [31:0]         data_q;

    logic                w_rise;
    logic                w_fall;
    logic                w_seq;
    logic [1:0]          w_lane;
    logic [SDRAM_AW-1:0] w_waddr;
    logic                w_flush;
    logic [31:0]         w_base;
    logic [31:0]         w_merged;
    logic                w_bpush;
    logic                w_ok0;
    logic [CW-1:0]       w_cnt1;
    logic                w_ok1;
    logic                w_drop;
    logic                w_pop;
    logic [PW-1:0]       w_wr1_ptr;
    logic                w_busy;
    logic                w_active;

    assign w_rise   = ioctl_download & ~dl_q;
    assign w_fall   = dl_q & ~ioctl_download;
    assign w_seq    = first_q | w_rise | (ioctl_addr == prev_addr_q + IOCTL_AW'(1));
    assign w_lane   = ioctl_addr[1:0];
    assign w_waddr  = SDRAM_AW'(BASE_ADDR) + SDRAM_AW'(ioctl_addr[IOCTL_AW-1:2]);

    // A pending partial word leaves either on an address jump or after the end of download.
    assign w_flush  = asm_valid_q & ~w_rise & ((ioctl_wr & ~w_seq) | end_pend_q);
    assign w_base   = (w_flush | w_rise) ? 32'h0 : asm_data_q;
    assign w_merged = w_base | ({24'h0, ioctl_data} << {w_lane, 3'b000});
    assign w_bpush  = ioctl_wr & (w_lane == 2'd3);

    // Flush word takes the first free slot, the completed byte word the next one.
    assign w_ok0     = w_flush & (count_q < CW'(FIFO_DEPTH));
    assign w_cnt1    = count_q + CW'(w_ok0);
    assign w_ok1     = w_bpush & (w_cnt1 < CW'(FIFO_DEPTH));
    assign w_drop    = (w_flush & ~w_ok0) | (w_bpush & ~w_ok1);
    assign w_pop     = (state_q == S_REQ) & sdram_ack;
    assign w_wr1_ptr = wr_ptr_q + PW'(w_ok0);

    assign w_busy   = ioctl_download | (count_q != '0) | (state_q == S_REQ) | asm_valid_q;
    assign w_active = w_busy | end_pend_q | ioctl_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            first_q     <= 1'b1;
            end_pend_q  <= 1'b0;
            session_q   <= 1'b0;
            active_q    <= 1'b0;
            asm_valid_q <= 1'b0;
            asm_data_q  <= 32'h0;
            asm_addr_q  <= '0;
            prev_addr_q <= '0;
            seq_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            end_pend_q <= w_fall;
            active_q   <= w_active;

            if (w_rise) begin
                first_q <= 1'b1;
            end
            if (ioctl_wr) begin
                first_q     <= 1'b0;
                prev_addr_q <= ioctl_addr;
            end

            if (ioctl_wr) begin
                if (w_bpush) begin
                    asm_valid_q <= 1'b0;
                    asm_data_q  <= 32'h0;
                end else begin
                    asm_valid_q <= 1'b1;
                    asm_data_q  <= w_merged;
                    asm_addr_q  <= w_waddr;
                end
            end else if (w_flush | w_rise) begin
                asm_valid_q <= 1'b0;
                asm_data_q  <= 32'h0;
            end

            if (w_rise) begin
                seq_err_q <= 1'b0;
                ovf_q     <= 1'b0;
                done_q    <= 1'b0;
            end
            if (ioctl_wr & ~w_seq) begin
                seq_err_q <= 1'b1;
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
            end

            if (w_rise) begin
                session_q <= 1'b1;
            end else if (session_q & active_q & ~w_active) begin
                session_q <= 1'b0;
                done_q    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(w_ok0) + PW'(w_ok1);
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(w_ok0) + CW'(w_ok1) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ok0) begin
            fifo_addr_q[wr_ptr_q] <= asm_addr_q;
            fifo_data_q[wr_ptr_q] <= asm_data_q;
        end
        if (w_ok1) begin
            fifo_addr_q[w_wr1_ptr] <= w_waddr;
            fifo_data_q[w_wr1_ptr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_REQ;
            S_REQ:   if (sdram_ack)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sdram_req = 1'b0;
        if (state_q == S_REQ) begin
            sdram_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= 32'h0;
        end else if ((state_q == S_IDLE) && (count_q != '0)) begin
            addr_q <= fifo_addr_q[rd_ptr_q];
            data_q <= fifo_data_q[rd_ptr_q];
        end
    end

    assign sdram_we   = sdram_req;
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign ioctl_wait = (count_q >= CW'(FIFO_DEPTH - 1));
    assign busy       = w_busy;
    assign done       = done_q;
    assign seq_error  = seq_err_q;
    assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_download_writer.sv
// Directed bench for rom_download_writer with an SDRAM ack responder and write monitor.
`default_nettype none

module tb_rom_download_writer;

    localparam int IAW   = 20;
    localparam int SAW   = 23;
    localparam int BASE  = 256;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [IAW-1:0] ioctl_addr;
    logic [7:0]     ioctl_data;
    logic           ioctl_wr;
    logic           ioctl_download;
    logic           ioctl_wait;
    logic [SAW-1:0] sdram_addr;
    logic [31:0]    sdram_data;
    logic           sdram_we;
    logic           sdram_req;
    logic           sdram_ack;
    logic           busy;
    logic           done;
    logic           seq_error;
    logic           overflow;

    rom_download_writer #(
        .IOCTL_AW(IAW), .SDRAM_AW(SAW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .busy(busy), .done(done), .seq_error(seq_error), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int             n_total = 0;
    int             n_bad   = 0;
    int             ack_dly = 0;
    int             wait_cnt = 0;
    logic [SAW-1:0] wa [$];
    logic [31:0]    wd [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input int ea, input logic [31:0] ed);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, 64'(wa[idx]), 64'(ea));
            chk({tag, "_data"}, 64'(wd[idx]), 64'(ed));
        end else begin
            chk({tag, "_missing"}, 64'(wa.size()), 64'(idx + 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller model: acks ack_dly cycles after req is first seen.
    initial begin : g_responder
        int cnt;
        cnt = 0;
        sdram_ack = 1'b0;
        forever begin
            tick();
            sdram_ack = 1'b0;
            if (sdram_req) begin
                if (cnt >= ack_dly) begin
                    sdram_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : g_monitor
        forever begin
            @(posedge clk);
            if (sdram_req && sdram_ack) begin
                wa.push_back(sdram_addr);
                wd.push_back(sdram_data);
            end
            if (ioctl_wait) wait_cnt++;
        end
    end

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] sbyte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [31:0] sword(input int k);
        return {sbyte(4*k+3), sbyte(4*k+2), sbyte(4*k+1), sbyte(4*k)};
    endfunction

    task automatic send(input int a, input logic [7:0] d, input bit honour);
        int n;
        n = 0;
        if (honour) begin
            while (ioctl_wait && n < 1000) begin
                ioctl_wr = 1'b0;
                tick();
                n++;
            end
            if (n >= 1000) chk("wait_stuck", 64'(ioctl_wait), 64'(0));
        end
        ioctl_addr = IAW'(a);
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin : g_main
        int b0;
        int n0;
        int w0;
        reset          = 1'b1;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("rst_outs", 64'({sdram_req, sdram_we, ioctl_wait, busy, done, seq_error, overflow}), 64'(0));
        chk("rst_addr", 64'(sdram_addr), 64'(0));
        chk("rst_data", 64'(sdram_data), 64'(0));
        reset = 1'b0;
        repeat (5) tick();
        chk("no_done_after_reset", 64'(done), 64'(0));

        // Aligned 8-byte download, fast ack.
        ack_dly = 0;
        b0 = wa.size();
        start_dl();
        for (int i = 0; i < 8; i++) send(i, 8'(17 * (i + 1)), 1'b1);
        end_dl();
        wait_done("t1_done");
        chk("t1_count", 64'(wa.size() - b0), 64'(2));
        chk_wr("t1_w0", b0, BASE, 32'h44332211);
        chk_wr("t1_w1", b0 + 1, BASE + 1, 32'h88776655);
        chk("t1_flags", 64'({seq_error, overflow, busy}), 64'(0));
        repeat (3) tick();
        chk("t1_done_held", 64'(done), 64'(1));

        // 6 bytes: partial word flushed after the fall.
        b0 = wa.size();
        start_dl();
        chk("t2_done_clr", 64'(done), 64'(0));
        for (int i = 0; i < 6; i++) send(i, 8'(17 * (i + 1)), 1'b1);
        ioctl_wr = 1'b0;
        chk("t2_before_fall", 64'(wa.size() - b0 <= 1), 64'(1));
        end_dl();
        wait_done("t2_done");
        chk("t2_count", 64'(wa.size() - b0), 64'(2));
        chk_wr("t2_w0", b0, BASE, 32'h44332211);
        chk_wr("t2_w1", b0 + 1, BASE + 1, 32'h00006655);

        // Back-to-back bytes, slow ack, honouring ioctl_wait.
        ack_dly = 20;
        b0 = wa.size();
        w0 = wait_cnt;
        start_dl();
        for (int i = 0; i < 32; i++) send(i, sbyte(i), 1'b1);
        end_dl();
        wait_done("t3_done");
        chk("t3_wait_seen", 64'(wait_cnt > w0), 64'(1));
        chk("t3_overflow", 64'(overflow), 64'(0));
        chk("t3_count", 64'(wa.size() - b0), 64'(8));
        for (int k = 0; k < 8; k++) chk_wr($sformatf("t3_w%0d", k), b0 + k, BASE + k, sword(k));

        // Same stream ignoring ioctl_wait.
        b0 = wa.size();
        start_dl();
        chk("t4_ovf_clr", 64'(overflow), 64'(0));
        for (int i = 0; i < 32; i++) send(i, sbyte(i), 1'b0);
        end_dl();
        wait_done("t4_done");
        chk("t4_overflow", 64'(overflow), 64'(1));
        for (int k = 0; k < 4; k++) chk_wr($sformatf("t4_w%0d", k), b0 + k, BASE + k, sword(k));

        // Address jump 0,1,8.
        ack_dly = 0;
        b0 = wa.size();
        start_dl();
        send(0, 8'h11, 1'b1);
        send(1, 8'h22, 1'b1);
        send(8, 8'h33, 1'b1);
        end_dl();
        wait_done("t5_done");
        chk("t5_seq_error", 64'(seq_error), 64'(1));
        chk("t5_count", 64'(wa.size() - b0), 64'(2));
        chk_wr("t5_w0", b0, BASE, 32'h00002211);
        chk_wr("t5_w1", b0 + 1, BASE + 2, 32'h00000033);

        // Reset with a request outstanding and two words buffered.
        ack_dly = 100000;
        start_dl();
        chk("t6_seq_clr", 64'(seq_error), 64'(0));
        for (int i = 0; i < 8; i++) send(i, sbyte(i), 1'b1);
        ioctl_wr = 1'b0;
        repeat (3) tick();
        chk("t6_req_pre", 64'(sdram_req), 64'(1));
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        chk("t6_req_drop", 64'(sdram_req), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        chk("t6_wait", 64'(ioctl_wait), 64'(0));
        reset = 1'b0;
        n0 = wa.size();
        repeat (30) tick();
        chk("t6_no_req", 64'(sdram_req), 64'(0));
        chk("t6_no_writes", 64'(wa.size()), 64'(n0));
        chk("t6_done_after", 64'(done), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
